bpm_frame_sequencer: RTL

- Downstream consumer of the four 17-bit per-train integrated BPM sums (bpm1_i/q, bpm2_i/q) produced by the bunch integrator.
- Tracks bunch strobes to find the end of each integration window and captures the four sums at the correct cycle, before the integrator clears.
- Scales and saturates each sum, then serialises the four channels over a valid/ready handshake to the feedback/DAC stage.

---
 rtl/bpm_frame_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/bpm_frame_sequencer.sv
// Captures the four integrated BPM sums at the end of each bunch train, scales and saturates them,
// and serialises them over valid/ready. Define BPM_SEQ_ROUND_EN to round half up before the shift.
module bpm_frame_sequencer #(
   parameter int unsigned N_BUNCH = 4,
   parameter int unsigned SHIFT   = 2,
   parameter int unsigned OUT_W   = 14,
   parameter int unsigned SETTLE  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    bunch_strb,
   input  logic                    dac_cond,
   input  logic signed [16:0]      bpm1_i_int,
   input  logic signed [16:0]      bpm1_q_int,
   input  logic signed [16:0]      bpm2_i_int,
   input  logic signed [16:0]      bpm2_q_int,
   output logic signed [OUT_W-1:0] out_data,
   output logic [1:0]              out_chan,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last,
   output logic                    short_train,
   output logic                    overrun,
   input  logic                    ovr_clr,
   output logic [15:0]             frame_cnt
);

   typedef enum logic [1:0] {StIdle, StTrain, StSettle, StEmit} state_e;

   localparam int unsigned CntW = $clog2(N_BUNCH + 1);
   localparam logic signed [17:0] SatMax = 18'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [17:0] SatMin = -SatMax - 18'sd1;
`ifdef BPM_SEQ_ROUND_EN
   localparam int unsigned RndSh = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [17:0] RndAdd = (SHIFT > 0) ? 18'(1 << RndSh) : 18'sd0;
`endif

   state_e                  state_q;
   logic [CntW-1:0]         cnt_q;
   logic [7:0]              tmr_q;
   logic                    short_pend_q;
   logic signed [OUT_W-1:0] hold_q [4];
   logic signed [OUT_W-1:0] out_data_q;
   logic [1:0]              out_chan_q;
   logic                    out_valid_q;
   logic                    out_last_q;
   logic                    short_train_q;
   logic                    overrun_q;
   logic [15:0]             frame_cnt_q;

   logic                    hs;
   logic                    last_hs;
   logic                    ovr_set;
   logic [CntW-1:0]         cnt_inc;
   logic [1:0]              chan_inc;
   logic signed [OUT_W-1:0] sc [4];

   // 18-bit intermediate keeps the rounding add from overflowing
   function automatic logic signed [OUT_W-1:0] scale(input logic signed [16:0] s);
      logic signed [17:0] w;
      w = $signed({s[16], s});
`ifdef BPM_SEQ_ROUND_EN
      w = w + RndAdd;
`endif
      w = w >>> SHIFT;
      if (w > SatMax) begin
         scale = SatMax[OUT_W-1:0];
      end else if (w < SatMin) begin
         scale = SatMin[OUT_W-1:0];
      end else begin
         scale = w[OUT_W-1:0];
      end
   endfunction

   assign sc[0]    = scale(bpm1_i_int);
   assign sc[1]    = scale(bpm1_q_int);
   assign sc[2]    = scale(bpm2_i_int);
   assign sc[3]    = scale(bpm2_q_int);
   assign hs       = out_valid_q & out_ready;
   assign last_hs  = hs & (out_chan_q == 2'd3);
   assign cnt_inc  = cnt_q + CntW'(1);
   assign chan_inc = out_chan_q + 2'd1;
   // A strobe on the final handshake starts the next train, so it is not an overrun
   assign ovr_set  = bunch_strb & ((state_q == StSettle) | ((state_q == StEmit) & ~last_hs));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         tmr_q         <= '0;
         short_pend_q  <= 1'b0;
         hold_q        <= '{default: '0};
         out_data_q    <= '0;
         out_chan_q    <= '0;
         out_valid_q   <= 1'b0;
         out_last_q    <= 1'b0;
         short_train_q <= 1'b0;
         overrun_q     <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         if (ovr_set) begin
            overrun_q <= 1'b1;
         end else if (ovr_clr) begin
            overrun_q <= 1'b0;
         end

         unique case (state_q)
            StIdle: begin
               if (bunch_strb) begin
                  cnt_q        <= CntW'(1);
                  short_pend_q <= 1'b0;
                  if (N_BUNCH == 1) begin
                     state_q <= StSettle;
                     tmr_q   <= 8'(SETTLE - 1);
                  end else begin
                     state_q <= StTrain;
                  end
               end
            end
            StTrain: begin
               if (bunch_strb) begin
                  cnt_q <= cnt_inc;
                  if (cnt_inc == CntW'(N_BUNCH)) begin
                     state_q      <= StSettle;
                     tmr_q        <= 8'(SETTLE - 1);
                     short_pend_q <= 1'b0;
                  end
               end else if (dac_cond) begin
                  state_q      <= StSettle;
                  tmr_q        <= 8'd0;
                  short_pend_q <= 1'b1;
               end
            end
            StSettle: begin
               if (tmr_q == 8'd0) begin
                  hold_q        <= sc;
                  out_data_q    <= sc[0];
                  out_chan_q    <= 2'd0;
                  out_valid_q   <= 1'b1;
                  out_last_q    <= 1'b0;
                  short_train_q <= short_pend_q;
                  cnt_q         <= '0;
                  state_q       <= StEmit;
               end else begin
                  tmr_q <= tmr_q - 8'd1;
               end
            end
            StEmit: begin
               if (last_hs) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  frame_cnt_q <= frame_cnt_q + 16'd1;
                  if (bunch_strb) begin
                     cnt_q        <= CntW'(1);
                     short_pend_q <= 1'b0;
                     if (N_BUNCH == 1) begin
                        state_q <= StSettle;
                        tmr_q   <= 8'(SETTLE - 1);
                     end else begin
                        state_q <= StTrain;
                     end
                  end else begin
                     state_q <= StIdle;
                  end
               end else if (hs) begin
                  out_chan_q <= chan_inc;
                  out_data_q <= hold_q[chan_inc];
                  out_last_q <= (chan_inc == 2'd3);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign out_data    = out_data_q;
   assign out_chan    = out_chan_q;
   assign out_valid   = out_valid_q;
   assign out_last    = out_last_q;
   assign short_train = short_train_q;
   assign overrun     = overrun_q;
   assign frame_cnt   = frame_cnt_q;

endmodule
